rf_debug_reader: RTL and testbench
==================================

// Module: rf_debug_reader
// PURPOSE
//   Debug-side reader for the CPU register file. On a start pulse it scans a
//   contiguous (wrapping) address range through the register file's spare
//   asynchronous read port. Each register is streamed out as {addr, data} beats
//   on a valid/ready interface. Sits between reg_file read port 2 and the
//   debug/display logic, so the whole register set can be dumped without
//   stalling the datapath.
// PARAMETERS
//   ADDR_WIDTH  5   register address width (2**ADDR_WIDTH registers)
//   DATA_WIDTH  32  register data width
// PORTS
//   clk         in   1           clock; all state updates on posedge
//   rstn        in   1           asynchronous reset, active-low
//   start       in   1           1-cycle request to begin a scan; ignored while busy
//   abort       in   1           synchronous cancel of the scan in progress
//   first_addr  in   ADDR_WIDTH  first register of the scan, sampled with start
//   last_addr   in   ADDR_WIDTH  last register of the scan, sampled with start
//   rf_ra       out  ADDR_WIDTH  read address to the register file (registered)
//   rf_rd       in   DATA_WIDTH  asynchronous read data returned for rf_ra
//   out_valid   out  1           beat available
//   out_ready   in   1           consumer accepts the beat when out_valid & out_ready
//   out_addr    out  ADDR_WIDTH  register index of the current beat
//   out_data    out  DATA_WIDTH  register value of the current beat
//   out_last    out  1           current beat is the last_addr register
//   busy        out  1           high in every state except IDLE
//   done        out  1           1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//   - Clock and reset: one clock, clk; asynchronous active-low reset, rstn.
//   - Reset state: FSM=IDLE; rf_ra, out_addr and out_data = 0; out_valid,
//     out_last, busy and done = 0.
//   - FSM states: IDLE, READ, SEND, DONE.
//   - IDLE, start=1 and abort=0: latch cur=first_addr and end=last_addr; drive
//     rf_ra<=first_addr; go to READ.
//   - READ (exactly 1 cycle):
//       rf_ra==cur is stable, so rf_rd is valid.
//       At the edge, capture out_data<=rf_rd, out_addr<=cur, out_last<=(cur==end).
//       Go to SEND.
//   - SEND:
//       out_valid=1. out_addr, out_data and out_last hold stable until the
//       handshake.
//       On out_valid & out_ready with out_last=1: go to DONE.
//       On out_valid & out_ready with out_last=0: cur<=cur+1 (mod 2**ADDR_WIDTH),
//       rf_ra<=cur+1, go to READ.
//   - DONE: done=1 for 1 cycle, then go to IDLE. out_valid=0.
//   - Throughput and latency:
//       At most 1 beat per 2 cycles.
//       First out_valid appears 2 cycles after the start cycle.
//       N registers with out_ready tied high take 2N cycles, and done follows
//       1 cycle after the final accept.
//   - Range rules:
//       first==last: exactly one beat.
//       first>last: the scan wraps through 2**ADDR_WIDTH-1 to 0.
//       The beat count is always ((last-first) mod 2**ADDR_WIDTH)+1.
//   - Coherence: data is the register value present during the READ cycle. A
//     CPU write landing on that same edge is NOT reflected, because the read
//     returns the old value.
//   - abort (any non-IDLE state):
//       Next state is IDLE; out_valid drops even if a beat is un-accepted.
//       done is not pulsed.
//       abort has priority over a same-cycle handshake and over start.
//   - start while busy: ignored; the scan in progress is unaffected.
//   - rstn low mid-scan: immediate return to reset state; no done pulse.
//   - rf_ra is driven only from flops and changes only on the READ transition.
// TESTING
//   - Full dump: preload rf[i]=32'hA5000000+i, first=0, last=31, ready=1
//     -> 32 beats addr 0..31 with matching data; out_last only on addr 31;
//     done at cycle 65.
//   - Backpressure: first=4, last=6, ready low 3 cycles per beat -> beats 4,5,6;
//     data/addr stable while stalled; no beat dropped or duplicated.
//   - Wrap: first=30, last=1 -> beats 30,31,0,1; out_last on addr 1; busy
//     throughout; done once.
//   - Single/conflict: first=last=7, with a CPU write of rf[7]=32'h1234 on the
//     READ edge -> 1 beat carrying the old value; a start during SEND is ignored.
//   - Abort/reset: abort during SEND of the 3rd beat -> out_valid=0 and IDLE
//     next cycle, no done. Repeat with rstn asserted mid-READ -> all outputs 0
//     immediately.

Source files
------------

// File: rtl/rf_debug_reader.sv
// rf_debug_reader: walks a contiguous, wrapping range of register-file
// addresses through the spare asynchronous read port. Each register is streamed
// out as one {addr, data, last} beat on a valid/ready interface.
//
// Handshake: a beat transfers on any rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_addr, out_data and out_last hold stable. out_valid never drops without a
// transfer, except on abort or reset.
module rf_debug_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rf_ra,
  input  logic [DATA_WIDTH-1:0] rf_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_q, cur_d;
  logic [ADDR_WIDTH-1:0]   end_q, end_d;
  logic [ADDR_WIDTH-1:0]   rf_ra_q, rf_ra_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   cur_inc;

  // The increment wraps naturally at 2**ADDR_WIDTH, which gives the wrapping scan.
  assign cur_inc = cur_q + ADDR_WIDTH'(1);

  // Next-state and next-output logic. All outputs are taken from flops so that
  // rf_ra in particular never glitches toward the register file.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    rf_ra_d     = rf_ra_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          cur_d   = first_addr;
          end_d   = last_addr;
          rf_ra_d = first_addr;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // rf_ra has been stable for a full cycle, so rf_rd is the value
          // held before this edge (a write on this same edge is not seen).
          out_data_d  = rf_rd;
          out_addr_d  = cur_q;
          out_last_d  = (cur_q == end_q);
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          // Abort wins over a handshake in the same cycle: the beat is dropped.
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cur_d   = cur_inc;
            rf_ra_d = cur_inc;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      rf_ra_q     <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      rf_ra_q     <= rf_ra_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rf_ra     = rf_ra_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_debug_reader.sv
// Testbench for rf_debug_reader: a register-file model on the async read port,
// directed scans pushing expected beats into a queue, and a monitor that pops
// and compares each accepted beat.
module tb_rf_debug_reader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int BW = AW + DW + 1;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] rf_ra;
  logic [DW-1:0] rf_rd;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  rf_debug_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_ra      (rf_ra),
    .rf_rd      (rf_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- register file model ----------------
  logic [DW-1:0] rf [32];
  logic          load;
  logic          cpu_we;
  logic [AW-1:0] cpu_wa;
  logic [DW-1:0] cpu_wd;

  assign rf_rd = rf[rf_ra];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA500_0000 + i;
    end else if (cpu_we) begin
      rf[cpu_wa] <= cpu_wd;
    end
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  bit            rf7_new = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 5'd7 && rf7_new) return 32'h0000_1234;
    return 32'hA500_0000 + DW'(a);
  endfunction

  // Push the expected beats of a scan; nmax truncates for aborted scans.
  task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l, input int nmax);
    logic [AW-1:0] diff;
    logic [AW-1:0] a;
    int n;
    diff = l - f;
    n = int'(diff) + 1;
    for (int k = 0; k < n && k < nmax; k++) begin
      a = f + AW'(k);
      exp_q.push_back({a, exp_data(a), (k == n - 1)});
    end
  endtask

  // ---------------- monitor ----------------
  logic          stall_seen = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  logic          held_last;

  always @(negedge clk) begin
    logic [BW-1:0] e;
    if (rstn) begin
      if (done) done_cnt++;
      if (stall_seen && out_valid) begin
        check("stall_addr_stable", out_addr, held_addr);
        check("stall_data_stable", out_data, held_data);
        check("stall_last_stable", out_last, held_last);
      end
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, none expected", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", out_addr, e[BW-1 -: AW]);
          check("beat_data", out_data, e[DW:1]);
          check("beat_last", out_last, e[0]);
          check("beat_rf_ra", rf_ra, e[BW-1 -: AW]);
        end
      end
      stall_seen = out_valid && !out_ready && !abort;
      held_addr  = out_addr;
      held_data  = out_data;
      held_last  = out_last;
    end else begin
      stall_seen = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_ra"},     rf_ra, 0);
    check({tag, "_out_addr"},  out_addr, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_state"},     dbg_state, 0);
  endtask

  // One complete scan. stall = cycles out_ready stays low per valid beat,
  // poke = fire an extra start while in SEND, wr7 = CPU write of rf[7] on
  // the READ edge, exp_cyc = edges from start edge to done (0 = skip).
  task automatic do_scan(input logic [AW-1:0] f, input logic [AW-1:0] l, input int stall,
                         input bit poke, input bit wr7, input int exp_cyc);
    int n, wcnt, first_v;
    bit got, busy_ok, poked;
    done_cnt = 0;
    push_range(f, l, 32);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    out_ready  = (stall == 0);
    tick();
    start = 1'b0;
    if (wr7) begin
      cpu_we = 1'b1;
      cpu_wa = 5'd7;
      cpu_wd = 32'h0000_1234;
    end
    n = 0; wcnt = 0; first_v = -1; got = 0; busy_ok = 1; poked = 0;
    while (n < 400) begin
      tick();
      n++;
      cpu_we = 1'b0;
      start  = 1'b0;
      if (done) begin
        got = 1;
        break;
      end
      if (!busy) busy_ok = 0;
      if (out_valid && first_v < 0) first_v = n;
      if (stall > 0) begin
        if (out_ready) out_ready = 1'b0;
        else if (out_valid) begin
          if (wcnt == stall) begin
            out_ready = 1'b1;
            wcnt = 0;
          end else wcnt++;
        end
      end
      if (poke && out_valid && !poked) begin
        start      = 1'b1;
        first_addr = 5'd20;
        last_addr  = 5'd25;
        poked      = 1;
      end
    end
    check("scan_done_seen", got, 1);
    check("scan_first_valid_latency", first_v, 1);
    check("scan_busy_throughout", busy_ok, 1);
    check("scan_busy_at_done", busy, 1);
    if (exp_cyc > 0) check("scan_cycles_to_done", n, exp_cyc);
    tick();
    check("after_done_low", done, 0);
    check("after_busy_low", busy, 0);
    check("after_state_idle", dbg_state, 0);
    check("after_done_pulses", done_cnt, 1);
    check("after_queue_empty", exp_q.size(), 0);
    out_ready = 1'b1;
  endtask

  task automatic do_abort();
    int n, beats;
    done_cnt = 0;
    push_range(5'd10, 5'd20, 2);
    first_addr = 5'd10;
    last_addr  = 5'd20;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n = 0; beats = 0;
    while (n < 100) begin
      tick();
      n++;
      if (out_valid) begin
        beats++;
        if (beats == 3) begin
          abort = 1'b1;
          break;
        end
      end
    end
    check("abort_reached_beat3", beats, 3);
    tick();
    abort = 1'b0;
    check("abort_valid_low", out_valid, 0);
    check("abort_busy_low", busy, 0);
    check("abort_state_idle", dbg_state, 0);
    repeat (4) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_mid_reset();
    int n;
    done_cnt = 0;
    push_range(5'd12, 5'd15, 1);
    first_addr = 5'd12;
    last_addr  = 5'd15;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n < 100 && !out_valid) begin
      tick();
      n++;
    end
    check("rst_first_beat_seen", out_valid, 1);
    tick();
    check("rst_in_read_state", dbg_state, 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rstn = 1'b1;
    tick();
    check("rst_no_done", done_cnt, 0);
    check("rst_queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    cpu_we = 1'b0; cpu_wa = '0; cpu_wd = '0;
    load = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) tick();
    load = 1'b0;
    rstn = 1'b1;
    tick();

    do_scan(5'd0,  5'd31, 0, 0, 0, 64);   // full dump
    do_scan(5'd4,  5'd6,  3, 0, 0, 15);   // backpressure
    do_scan(5'd30, 5'd1,  0, 0, 0, 8);    // wrap
    do_scan(5'd7,  5'd7,  2, 1, 1, 4);    // single + write conflict + start in SEND
    rf7_new = 1;
    do_scan(5'd7,  5'd7,  0, 0, 0, 2);    // new value now visible
    do_abort();
    do_mid_reset();
    do_scan(5'd0,  5'd2,  0, 0, 0, 6);    // recovery after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
